// File: rtl/alu_pkg.sv
// Shared constants for the ALU: opcode encodings and status bit positions.
package alu_pkg;

  // Operation select encodings.
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SLL = 3'b101;
  localparam logic [2:0] SRL = 3'b110;
  localparam logic [2:0] SRA = 3'b111;

  // Positions of the flags inside the 4-bit status word.
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/alu_addsub.sv
// Combinational XLEN-bit adder/subtractor.
// Subtraction is a + ~b + !cin, so cin acts as a borrow-in and cout=1 means
// "no borrow".
module alu_addsub #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic [XLEN-1:0] sum,
  output logic            cout,
  output logic            ovf
);

  logic [XLEN-1:0] b_eff;
  logic            cin_eff;
  logic [XLEN:0]   wide_sum;

  // Single XLEN+1-bit add of a, the conditioned operand and carry-in.
  always_comb begin
    b_eff    = sub ? ~b : b;
    cin_eff  = sub ? ~cin : cin;
    wide_sum = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin_eff};
    sum      = wide_sum[XLEN-1:0];
    cout     = wide_sum[XLEN];
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    ovf      = (a[XLEN-1] == b_eff[XLEN-1]) && (wide_sum[XLEN-1] != a[XLEN-1]);
  end

endmodule

// File: rtl/alu.sv
// Integer ALU with a one-cycle registered result and NZCV status word.
// There is no handshake: every rising edge captures the operands, and the
// outputs present the result of the operation captured on the previous edge.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            c,
  input  logic [2:0]      alu_op,
  output logic [3:0]      status,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] as_sum;
  logic            as_cout;
  logic            as_ovf;
  logic [SHW-1:0]  shamt;
  logic            is_arith;
  logic [XLEN-1:0] res_next;
  logic [3:0]      status_next;

  alu_addsub #(.XLEN(XLEN)) u_addsub (
    .a    (a),
    .b    (b),
    .cin  (c),
    .sub  (alu_op == SUB),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // Operation mux and flag generation; only arithmetic ops report C and V.
  always_comb begin
    shamt    = b[SHW-1:0];
    is_arith = (alu_op == ADD) || (alu_op == SUB);
    res_next = '0;
    case (alu_op)
      ADD, SUB: res_next = as_sum;
      AND:      res_next = a & b;
      OR:       res_next = a | b;
      XOR:      res_next = a ^ b;
      SLL:      res_next = a << shamt;
      SRL:      res_next = a >> shamt;
      SRA:      res_next = $unsigned($signed(a) >>> shamt);
      default:  res_next = '0;
    endcase
    status_next        = '0;
    status_next[N_BIT] = res_next[XLEN-1];
    status_next[Z_BIT] = (res_next == '0);
    status_next[C_BIT] = is_arith & as_cout;
    status_next[V_BIT] = is_arith & as_ovf;
  end

  // Output registers; reset clears them at once and discards the in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      status <= '0;
    end else begin
      result <= res_next;
      status <= status_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: drivers push the expected {status,result} into a
// queue, a monitor pops one entry on each edge that captured an operation.
module tb_alu;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            c;
  logic [2:0]      alu_op;
  logic [3:0]      status;
  logic [XLEN-1:0] result;

  logic [XLEN+3:0] exp_q[$];
  int              checks;
  int              errors;

  alu #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .alu_op (alu_op),
    .status (status),
    .result (result)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [XLEN+3:0] act,
                       input logic [XLEN+3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got status=%b result=0x%08h, expected status=%b result=0x%08h",
               name, act[XLEN+3:XLEN], act[XLEN-1:0], exp[XLEN+3:XLEN], exp[XLEN-1:0]);
    end
  endtask

  // Drive one operation at the falling edge and queue its expected outcome.
  task automatic drive(input logic [2:0] op, input logic [XLEN-1:0] va,
                       input logic [XLEN-1:0] vb, input logic vc,
                       input logic [XLEN-1:0] er, input logic [3:0] es);
    @(negedge clk);
    alu_op = op;
    a      = va;
    b      = vb;
    c      = vc;
    exp_q.push_back({es, er});
    @(posedge clk);
  endtask

  // Monitor: each non-reset edge with a queued expectation is compared 1ns later.
  always @(posedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      logic [XLEN+3:0] e;
      e = exp_q.pop_front();
      #1;
      check("pipe", {status, result}, e);
    end
  end

  initial begin
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [XLEN-1:0] t;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    c      = 1'b0;
    alu_op = ADD;
    #12;
    check("reset_state", {status, result}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Establish a prior result of 5, then reset asynchronously mid-operation.
    drive(ADD, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000);
    @(negedge clk);
    a = 32'd40; b = 32'd2;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {status, result}, '0);
    @(posedge clk);
    #1;
    check("reset_hold", {status, result}, '0);
    @(negedge clk);
    rst = 1'b0;

    // ADD Fibonacci chain from 2+1 up to 144+89.
    x = 32'd2;
    y = 32'd1;
    while (x <= 32'd144) begin
      drive(ADD, x, y, 1'b0, x + y, 4'b0000);
      t = x;
      x = x + y;
      y = t;
    end
    drive(ADD, 32'd1, 32'd1, 1'b1, 32'd3, 4'b0000);
    drive(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 4'b0110);
    drive(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b1001);

    // SUB sweep a=i*i, b=i.
    for (int i = 0; i <= 99; i += 9) begin
      drive(SUB, 32'(i * i), 32'(i), 1'b0, 32'(i * i - i),
            (i == 0) ? 4'b0110 : 4'b0010);
    end
    drive(SUB, 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    drive(SUB, 32'd10, 32'd3, 1'b1, 32'd6, 4'b0010);

    // Logic and shifts.
    drive(OR,  32'd81, 32'd9, 1'b1, 32'd89, 4'b0000);
    drive(AND, 32'd81, 32'd9, 1'b0, 32'd1, 4'b0000);
    drive(XOR, 32'd81, 32'd9, 1'b0, 32'd88, 4'b0000);
    drive(SLL, 32'd1, 32'd31, 1'b0, 32'h8000_0000, 4'b1000);
    drive(SRA, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000, 4'b1000);
    drive(SRL, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000, 4'b0000);
    drive(SLL, 32'd1, 32'd33, 1'b0, 32'd2, 4'b0000);
    drive(AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'd0, 4'b0100);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Parameterised integer ALU for the RISC-V core datapath. Performs add/subtract with carry/borrow-in, bitwise logic and shifts on two XLEN-wide operands. Returns a registered result plus a 4-bit NZCV status word. Sits between the register-file read ports / immediate mux and the writeback/branch logic.

## Interface
- `XLEN`, default 32: operand and result width; must be a power of two, at least 8.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `a`  input  XLEN  operand A, unsigned bit vector.
- `b`  input  XLEN  operand B, unsigned bit vector.
- `c`  input  1  carry-in for ADD, borrow-in for SUB; ignored by other ops.
- `alu_op`  input  3  operation select (encodings below).
- `status`  output  4  flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- `result`  output  XLEN  operation result, two's-complement when read as signed.

## Operation
- Opcodes:
  - `ADD`=000: a + b + c.
  - `SUB`=001: a + ~b + !c, which is a − b − c.
  - `AND`=010: a & b.
  - `OR`=011: a | b.
  - `XOR`=100: a ^ b.
  - `SLL`=101: a << b[log2(XLEN)-1:0].
  - `SRL`=110: logical right shift of a by the same amount.
  - `SRA`=111: arithmetic right shift of a by the same amount.
- Shift amount uses only the low log2(XLEN) bits of b. Upper bits are ignored.
- Arithmetic uses a single XLEN+1-bit add of a, B' and cin:
  - ADD: B' = b, cin = c.
  - SUB: B' = ~b, cin = !c.
  - Result is wrap-around modulo 2^XLEN; no saturation.
- N = result[XLEN-1], all ops.
- Z = (result == 0), all ops.
- C:
  - ADD: carry out of bit XLEN-1.
  - SUB: adder carry out, so 1 means no borrow (a ≥ b + c unsigned).
  - All other ops: 0.
- V:
  - ADD and SUB: signed overflow = (a[MSB] == B'[MSB]) && (result[MSB] != a[MSB]).
  - All other ops: 0.

## Timing
- All inputs are sampled on the rising edge of `clk`. `result` and `status` are registered.
- Latency is exactly 1 cycle: outputs reflect the inputs present at the previous rising edge.
- Throughput is one operation per cycle, with no stall or handshake.
- Inputs are captured every cycle; there is no hold or enable.
- `rst` high clears `result` to 0 and `status` to 0000 immediately, independent of `clk`.
- While `rst` is high, outputs stay 0 and edges are ignored.
- First capture after release is the first rising edge with `rst` low.
- Asserting `rst` mid-stream discards the in-flight operation.
- Changing `alu_op` between edges has no effect until the next edge.

## Structure
- Package `alu_pkg` holds:
  - the eight 3-bit opcode constants (`ADD`, `SUB`, `AND`, `OR`, `XOR`, `SLL`, `SRL`, `SRA`);
  - status bit index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
- One sub-module, `alu_addsub`, is natural:
  - purely combinational XLEN-bit adder/subtractor;
  - inputs: a, b, cin, sub;
  - outputs: sum, cout, ovf.
- Logic ops, shifter, flag generation and output registers live in `alu`.

## Test plan
- Reset: assert `rst` mid-operation with prior result 5. Both outputs clear immediately, without waiting for a clock edge: result=0, status=0000.
- ADD Fibonacci: a=2, b=1, c=0 → next cycle result=3, status=0000.
  - Continue the sequence to 144+89 → 233, status=0000.
  - Carry-in: a=1, b=1, c=1 → 3.
- ADD wrap: a=0xFFFFFFFF, b=1, c=0 → result=0, status=0110 (Z, C).
- ADD signed overflow: a=0x7FFFFFFF, b=1 → result=0x80000000, status=1001 (N, V).
- SUB sweep: a=i², b=i for i=0,9,…,99, c=0 → result=i²−i, C=1.
  - i=0 gives result=0, status=0110.
  - i=9 gives 72, status=0010.
  - Borrow case: a=0, b=1 → 0xFFFFFFFF, status=1000.
- Logic and shift sweep, C=0 and V=0 in every case:
  - OR of a=81, b=9 → 89.
  - AND of a=81, b=9 → 1.
  - XOR of a=81, b=9 → 88.
  - SLL of 1 by 31 → 0x80000000, status=1000.
  - SRA of 0x80000000 by 4 → 0xF8000000.
  - SRL of 0x80000000 by 4 → 0x08000000.
  - SLL of a=1, b=33 → 2 (b masked to 5 bits).
